// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared opcode constants and controller state encoding for
// mem_access_ctrl and its helpers.
//   OP_ADR / OP_LDR / OP_STR : decoded memory-stage opcodes (all others are ALU)
//   state_e                  : ST_IDLE / ST_REQ / ST_RESP
package mem_ctrl_pkg;

  localparam logic [3:0] OP_ADR = 4'b1100;
  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True for ops that need a RAM transaction.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: RAM request/acknowledge bus.
//   ram_req   : access request (held until ram_ack)
//   ram_rw    : 1 = read, 0 = write
//   ram_addr  : access address, stable while ram_req
//   ram_wdata : write data, stable while ram_req
//   ram_rdata : read data, valid with ram_ack
//   ram_ack   : RAM completes the access this cycle
// Modports: master = controller side, slave = RAM side.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              ram_req;
  logic              ram_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  modport master (
    output ram_req,
    output ram_rw,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata,
    input  ram_ack
  );

  modport slave (
    input  ram_req,
    input  ram_rw,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata,
    output ram_ack
  );

endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: RAM wait-state counter with expiry flag. Only instantiated
// when MEM_TIMEOUT_EN is defined.
//   clk, Reset_n : clock, async active-low reset
//   clear        : restart the count (pulsed when a RAM op is accepted)
//   count_en     : a REQ cycle passed without ack
//   expired      : count has reached WAIT_MAX
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

  logic [CntW-1:0] count_q;

  assign expired = (count_q == CntW'(WAIT_MAX));

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_en && !expired) begin
      count_q <= count_q + CntW'(1);
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequential memory-stage controller. Runs one LDR / STR / ADR /
// ALU-writeback op at a time: valid/ready handshake from decode, req/ack to RAM
// (arbitrary wait states), one-cycle done/reg_we strobe towards writeback.
// Optional build macro MEM_TIMEOUT_EN: abort a RAM access after WAIT_MAX
// unacknowledged REQ cycles (done + err, no writeback).
// Ports:
//   clk, Reset_n                   : clock, async active-low reset
//   op_code, valid_in, ready_out   : decode handshake (op accepted in IDLE)
//   SR1, SR2, IV_Mov               : address, store data, ADR immediate
//   ALU_result, memory_enable      : ALU writeback value and enable
//   ram                            : RAM bus (master side)
//   reg_data, reg_we               : writeback value and 1-cycle strobe
//   str_enable                     : high while a store request is outstanding
//   done, err                      : op retired / op aborted (1-cycle pulses)
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic [3:0]        op_code,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] SR1,
  input  logic [DATA_W-1:0] SR2,
  input  logic [IMM_W-1:0]  IV_Mov,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic              memory_enable,
  mem_access_ctrl_if.master ram,
  output logic [DATA_W-1:0] reg_data,
  output logic              reg_we,
  output logic              str_enable,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] reg_data_q;
  logic              mem_en_q;
  logic              err_q;
  logic              accept;
  logic              timeout;
  logic              wb_op;

`ifdef MEM_TIMEOUT_EN
  logic expired;

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .clear    (accept),
    .count_en ((state_q == ST_REQ) && !ram.ram_ack),
    .expired  (expired)
  );

  // An ack in the expiry cycle still completes the access normally.
  assign timeout = (state_q == ST_REQ) && !ram.ram_ack && expired;
  assign err     = (state_q == ST_RESP) && err_q;
`else
  logic unused_wait_max;
  assign unused_wait_max = ^WAIT_MAX;
  assign timeout         = 1'b0;
  assign err             = 1'b0;
`endif

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          accept  = 1'b1;
          state_d = is_mem_op(op_code) ? ST_REQ : ST_RESP;
        end
      end
      ST_REQ: begin
        if (ram.ram_ack || timeout) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latches. reg_data_q is only written when a writeback will follow,
  // so it holds the previous writeback value otherwise.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      reg_data_q <= '0;
      mem_en_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= op_code;
        addr_q   <= SR1[ADDR_W-1:0];
        wdata_q  <= SR2;
        mem_en_q <= memory_enable;
        err_q    <= 1'b0;
        if (op_code == OP_ADR) begin
          reg_data_q <= DATA_W'(IV_Mov);
        end else if (!is_mem_op(op_code) && memory_enable) begin
          reg_data_q <= ALU_result;
        end
      end
      if (state_q == ST_REQ) begin
        if (ram.ram_ack) begin
          if (op_q == OP_LDR) begin
            reg_data_q <= ram.ram_rdata;
          end
        end else if (timeout) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign wb_op = (op_q == OP_LDR) || (op_q == OP_ADR) || (!is_mem_op(op_q) && mem_en_q);

  // All strobes decode straight from state so an async reset drops them at once.
  assign ready_out     = (state_q == ST_IDLE);
  assign ram.ram_req   = (state_q == ST_REQ);
  assign ram.ram_rw    = (state_q == ST_REQ) && (op_q == OP_LDR);
  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = wdata_q;
  assign str_enable    = (state_q == ST_REQ) && (op_q == OP_STR);
  assign done          = (state_q == ST_RESP);
  assign reg_we        = (state_q == ST_RESP) && !err_q && wb_op;
  assign reg_data      = reg_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized ops, checked
// against an op-level reference model (latency, RAM cycles, writeback result).
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 16;
  localparam int unsigned WM = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          Reset_n;
  logic [3:0]    op_code;
  logic          valid_in;
  logic          ready_out;
  logic [DW-1:0] SR1, SR2, ALU_result;
  logic [IW-1:0] IV_Mov;
  logic          memory_enable;
  logic [DW-1:0] reg_data;
  logic          reg_we, str_enable, done, err;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] last_reg;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

  mem_access_ctrl #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .IMM_W    (IW),
    .WAIT_MAX (WM)
  ) dut (
    .clk           (clk),
    .Reset_n       (Reset_n),
    .op_code       (op_code),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .SR1           (SR1),
    .SR2           (SR2),
    .IV_Mov        (IV_Mov),
    .ALU_result    (ALU_result),
    .memory_enable (memory_enable),
    .ram           (ram_if),
    .reg_data      (reg_data),
    .reg_we        (reg_we),
    .str_enable    (str_enable),
    .done          (done),
    .err           (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op and follow it to retirement. waits = REQ cycles before ack.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [IW-1:0] iv,
                       input logic [DW-1:0] alu, input logic me, input int waits,
                       input logic [DW-1:0] rdata);
    bit            mem, tmo, exp_we, seen;
    logic [DW-1:0] exp_data;
    int            exp_req, exp_lat, lat, req_cycles;

    // Reference model for the whole op.
    mem      = (op == OP_LDR) || (op == OP_STR);
    tmo      = mem && TO_EN && (waits > int'(WM));
    exp_req  = !mem ? 0 : (tmo ? int'(WM) + 1 : waits + 1);
    exp_lat  = !mem ? 1 : exp_req + 1;
    exp_we   = !tmo && ((op == OP_LDR) || (op == OP_ADR) || (!mem && me));
    exp_data = (op == OP_LDR) ? rdata : (op == OP_ADR) ? {{(DW-IW){1'b0}}, iv} : alu;
    if (exp_we) last_reg = exp_data;

    chk({tag, "/ready_in"}, ready_out, 1);
    op_code = op; SR1 = a; SR2 = b; IV_Mov = iv; ALU_result = alu; memory_enable = me;
    valid_in = 1'b1;
    tick;
    // Scramble operand inputs: the controller must use its latched copies.
    SR1 = $urandom; SR2 = $urandom; IV_Mov = IW'($urandom); ALU_result = $urandom;
    memory_enable = 1'($urandom);
    lat = 1; req_cycles = 0; seen = 0;
    while (!seen && lat < 40) begin
      if (done) begin
        seen = 1;
      end else begin
        if (ram_if.ram_req) begin
          req_cycles++;
          chk({tag, "/rw"}, ram_if.ram_rw, op == OP_LDR);
          chk({tag, "/addr"}, ram_if.ram_addr, a);
          chk({tag, "/wdata"}, ram_if.ram_wdata, b);
          chk({tag, "/str_en"}, str_enable, op == OP_STR);
          ram_if.ram_ack   = (req_cycles == waits + 1);
          ram_if.ram_rdata = ram_if.ram_ack ? rdata : $urandom;
        end
        // Requests while busy must be dropped.
        valid_in = 1'($urandom);
        op_code  = 4'($urandom);
        tick;
        ram_if.ram_ack = 1'b0;
        lat++;
      end
    end
    valid_in = 1'b0;
    chk({tag, "/done_seen"}, seen, 1);
    chk({tag, "/latency"}, lat, exp_lat);
    chk({tag, "/req_cycles"}, req_cycles, exp_req);
    chk({tag, "/reg_we"}, reg_we, exp_we);
    chk({tag, "/reg_data"}, reg_data, last_reg);
    chk({tag, "/err"}, err, tmo);
    chk({tag, "/req_off"}, ram_if.ram_req, 0);
    ram_if.ram_ack = 1'($urandom);  // stray ack outside REQ
    tick;
    ram_if.ram_ack = 1'b0;
    chk({tag, "/ready_after"}, ready_out, 1);
    chk({tag, "/done_after"}, done, 0);
    chk({tag, "/we_after"}, reg_we, 0);
  endtask

  initial begin
    logic [3:0] rop;
    int         sel;

    Reset_n = 1'b0; op_code = '0; valid_in = 1'b0; SR1 = '0; SR2 = '0; IV_Mov = '0;
    ALU_result = '0; memory_enable = 1'b0;
    ram_if.ram_ack = 1'b0; ram_if.ram_rdata = '0;
    last_reg = '0;
    #2;
    chk("rst/ready", ready_out, 1);
    chk("rst/req", ram_if.ram_req, 0);
    chk("rst/done", done, 0);
    chk("rst/we", reg_we, 0);
    chk("rst/err", err, 0);
    chk("rst/str_en", str_enable, 0);
    chk("rst/reg_data", reg_data, 0);
    @(negedge clk);
    Reset_n = 1'b1;
    tick;

    do_op("t1_adr", OP_ADR, 32'h1, 32'h2, 16'hBEEF, 32'h3, 1'b0, 0, 32'h0);
    do_op("t2_str", OP_STR, 32'h40, 32'hDEADBEEF, 16'h0, 32'h0, 1'b0, 3, 32'h0);
    do_op("t3_ldr", OP_LDR, 32'h44, 32'h0, 16'h0, 32'h0, 1'b0, 0, 32'h12345678);
    do_op("t4_alu0", 4'b0000, 32'h0, 32'h0, 16'h0, 32'h7, 1'b0, 0, 32'h0);
    do_op("t4_alu1", 4'b0000, 32'h0, 32'h0, 16'h0, 32'h7, 1'b1, 0, 32'h0);

    // Reset in the middle of a store request.
    op_code = OP_STR; SR1 = 32'h80; SR2 = 32'hCAFE0001; valid_in = 1'b1;
    tick;
    valid_in = 1'b0;
    tick;
    chk("t5/req_before", ram_if.ram_req, 1);
    Reset_n = 1'b0;
    #1;
    chk("t5/req_drop", ram_if.ram_req, 0);
    chk("t5/str_drop", str_enable, 0);
    chk("t5/done_drop", done, 0);
    ram_if.ram_ack = 1'b1; ram_if.ram_rdata = 32'hBAD0BAD0;
    tick;
    Reset_n = 1'b1;
    last_reg = '0;
    tick;
    tick;
    chk("t5/ready", ready_out, 1);
    chk("t5/req", ram_if.ram_req, 0);
    chk("t5/done", done, 0);
    chk("t5/we", reg_we, 0);
    chk("t5/reg_data", reg_data, 0);
    ram_if.ram_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    do_op("t6_tmo_ldr", OP_LDR, 32'h100, 32'h0, 16'h0, 32'h0, 1'b0, 100, 32'h55);
    do_op("t6_tmo_str", OP_STR, 32'h104, 32'h77, 16'h0, 32'h0, 1'b0, 100, 32'h0);
    do_op("t6_edge", OP_LDR, 32'h108, 32'h0, 16'h0, 32'h0, 1'b0, int'(WM), 32'hA5A5);
`endif

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: rop = OP_ADR;
        1: rop = OP_LDR;
        2: rop = OP_STR;
        default: begin
          rop = 4'($urandom_range(0, 12));
          if (rop == 4'd12) rop = 4'd15;
        end
      endcase
      do_op($sformatf("rnd%0d", i), rop, $urandom, $urandom, IW'($urandom), $urandom,
            1'($urandom), $urandom_range(0, 5), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
